// File: rtl/fxp_pkg.sv
// Shared fixed-point sqrt types and default Q format.
// Build option: FXP_SQRT_ROUND_EN selects round-to-nearest roots.
package fxp_pkg;

  localparam int FXP_N = 16;
  localparam int FXP_R = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } sqrt_state_t;

endpackage

// File: rtl/fxp_sqrt_lane.sv
// One lane of the restoring digit-by-digit square root.
// Build option: FXP_SQRT_ROUND_EN rounds the root to nearest.
module fxp_sqrt_lane
  import fxp_pkg::*;
#(
  parameter int WIDTH = FXP_N,
  parameter int FBITS = FXP_R
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
  input  logic             fin,
  input  logic [WIDTH-1:0] rad,
  output logic [WIDTH-1:0] root,
  output logic [WIDTH-1:0] rem,
  output logic             err
);

  localparam int T    = WIDTH + FBITS;
  localparam int ITER = T / 2;
  localparam int AW   = ITER + 2;

  logic [T-1:0]    x;
  logic [ITER-1:0] q;
  logic [AW-1:0]   ac;
  logic            neg;

  logic [AW-1:0]   ac_sh;
  logic [AW:0]     diff;
  logic            ge;
  logic [AW-1:0]   ac_nxt;
  logic [ITER-1:0] q_nxt;
  logic [WIDTH-1:0] root_nxt;

  // Test-subtract: bring down two radicand bits, try (q<<2)|1.
  always_comb begin
    ac_sh  = {ac[AW-3:0], x[T-1:T-2]};
    diff   = {1'b0, ac_sh} - {1'b0, q, 2'b01};
    ge     = ~diff[AW];
    ac_nxt = ge ? diff[AW-1:0] : ac_sh;
    q_nxt  = {q[ITER-2:0], ge};
`ifdef FXP_SQRT_ROUND_EN
    root_nxt = WIDTH'(q_nxt)
             + WIDTH'(ac_nxt > {2'b00, q_nxt});
`else
    root_nxt = WIDTH'(q_nxt);
`endif
  end

  // Iteration registers and the result held for the consumer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x    <= '0;
      q    <= '0;
      ac   <= '0;
      neg  <= 1'b0;
      root <= '0;
      rem  <= '0;
      err  <= 1'b0;
    end else begin
      if (load) begin
        // A negative lane runs on zero so it ends as root 0, rem 0.
        x   <= rad[WIDTH-1] ? '0 : (T'(rad) << FBITS);
        q   <= '0;
        ac  <= '0;
        neg <= rad[WIDTH-1];
      end else if (step) begin
        x  <= x << 2;
        q  <= q_nxt;
        ac <= ac_nxt;
      end
      if (fin) begin
        root <= root_nxt;
        rem  <= WIDTH'(ac_nxt);
        err  <= neg;
      end
    end
  end

endmodule

// File: rtl/fxp_sqrt_vec.sv
// Vector fixed-point square root: LANES lanes, shared FSM.
// Build option: FXP_SQRT_ROUND_EN rounds roots to nearest.
module fxp_sqrt_vec
  import fxp_pkg::*;
#(
  parameter int WIDTH = FXP_N,
  parameter int FBITS = FXP_R,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_rad,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_root,
  output logic [LANES*WIDTH-1:0] out_rem,
  output logic [LANES-1:0]       out_err,
  output logic                   busy
);

  localparam int ITER = (WIDTH + FBITS) / 2;
  localparam int CW   = $clog2(ITER + 1);

  if (((WIDTH + FBITS) % 2) != 0) begin : g_odd
    $error("WIDTH+FBITS must be even");
  end

  sqrt_state_t   state;
  logic [CW-1:0] cnt;
  logic          load;
  logic          step;
  logic          fin;

  // Lane controls decoded from the FSM state and counter.
  always_comb begin
    load = (state == IDLE) && in_valid;
    step = (state == CALC);
    fin  = step && (cnt == CW'(ITER - 1));
  end

  // Control FSM with registered handshake and busy outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= CALC;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CALC: begin
          if (cnt == CW'(ITER - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fxp_sqrt_lane #(
      .WIDTH(WIDTH),
      .FBITS(FBITS)
    ) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .load   (load),
      .step   (step),
      .fin    (fin),
      .rad    (in_rad[i*WIDTH +: WIDTH]),
      .root   (out_root[i*WIDTH +: WIDTH]),
      .rem    (out_rem[i*WIDTH +: WIDTH]),
      .err    (out_err[i])
    );
  end

endmodule

// File: tb/tb_fxp_sqrt_vec.sv
// Self-checking bench for fxp_sqrt_vec (WIDTH=16, FBITS=8).
// Honours FXP_SQRT_ROUND_EN in its reference model.
module tb_fxp_sqrt_vec;

  localparam int W = 16;
  localparam int F = 8;
  localparam int L = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [L*W-1:0] in_rad = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [L*W-1:0] out_root;
  logic [L*W-1:0] out_rem;
  logic [L-1:0]   out_err;
  logic           busy;

  int total = 0;
  int bad   = 0;

  logic [L*W-1:0] got_root;
  logic [L*W-1:0] got_rem;
  logic [L-1:0]   got_err;

  fxp_sqrt_vec #(.WIDTH(W), .FBITS(F), .LANES(L)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_rad   (in_rad),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_root (out_root),
    .out_rem  (out_rem),
    .out_err  (out_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Reference: floor(sqrt(rad * 2^F)) by plain search.
  task automatic model(input logic [W-1:0] r, output logic [W-1:0] rt,
                       output logic [W-1:0] rm, output logic e);
    longint n;
    longint s;
    e  = r[W-1];
    rt = '0;
    rm = '0;
    if (!e) begin
      n = longint'(r) << F;
      s = 0;
      while ((s + 1) * (s + 1) <= n) s++;
      rm = W'(n - s * s);
`ifdef FXP_SQRT_ROUND_EN
      if ((n - s * s) > s) s++;
`endif
      rt = W'(s);
    end
  endtask

  task automatic run_vec(input logic [L*W-1:0] v, input int hold);
    int n;
    logic [W-1:0] ert, erm;
    logic ee;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_rad   = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_rad   = {$urandom, $urandom};
    chk("busy_calc", busy, 1);
    chk("in_ready_calc", in_ready, 0);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if (out_valid) break;
    end
    chk("latency", n, 12);
    got_root = out_root;
    got_rem  = out_rem;
    got_err  = out_err;
    for (int i = 0; i < L; i++) begin
      model(v[i*W +: W], ert, erm, ee);
      chk($sformatf("root%0d", i), got_root[i*W +: W], ert);
      chk($sformatf("rem%0d", i), got_rem[i*W +: W], erm);
      chk($sformatf("err%0d", i), got_err[i], ee);
    end
    for (int d = 0; d < hold; d++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_root", out_root, got_root);
      chk("hold_rem", out_rem, got_rem);
      chk("hold_err", out_err, got_err);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  initial begin
    int spur;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_root", out_root, 0);
    chk("rst_rem", out_rem, 0);
    chk("rst_err", out_err, 0);
    @(negedge clk);
    reset_n = 1'b1;

    run_vec({16'h0000, 16'h0000, 16'h0000, 16'h1000}, 0);
    chk("c34_root", got_root[15:0], 16'h0400);
    chk("c34_rem", got_rem[15:0], 16'h0000);

    run_vec({16'h6400, 16'h0000, 16'h0040, 16'h0200}, 0);
    chk("c35_r0", got_root[15:0], 16'h016A);
    chk("c35_r1", got_root[31:16], 16'h0080);
    chk("c35_r2", got_root[47:32], 16'h0000);
    chk("c35_r3", got_root[63:48], 16'h0A00);
    chk("c35_rem0", got_rem[15:0], 16'h001C);

    run_vec({16'h0000, 16'h0000, 16'h0000, 16'h0A00}, 5);
`ifdef FXP_SQRT_ROUND_EN
    chk("c36_root", got_root[15:0], 16'h032A);
`else
    chk("c36_root", got_root[15:0], 16'h0329);
`endif
    chk("c36_rem", got_rem[15:0], 16'h036F);

    run_vec({16'h0000, 16'h0000, 16'h0400, 16'hFF00}, 2);
    chk("c37_err", got_err, 4'b0001);
    chk("c37_nroot", got_root[15:0], 16'h0000);
    chk("c37_nrem", got_rem[15:0], 16'h0000);
    chk("c37_root", got_root[31:16], 16'h0200);

    @(negedge clk);
    in_rad   = {16'h1234, 16'h0A00, 16'h7FFF, 16'h0001};
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_root", out_root, 0);
    chk("ar_rem", out_rem, 0);
    chk("ar_err", out_err, 0);
    @(negedge clk);
    reset_n = 1'b1;
    spur = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) spur++;
    end
    chk("ar_spurious", spur, 0);
    chk("ar_ready", in_ready, 1);

    run_vec({16'h1234, 16'h0A00, 16'h7FFF, 16'h0001}, 1);

    for (int k = 0; k < 24; k++) begin
      run_vec({$urandom, $urandom}, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=hang exp=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fxp_sqrt_vec.md
FXP_SQRT_VEC -- requirements
Module: fxp_sqrt_vec

Interface
REQ-001 The block SHALL have parameter WIDTH, default FXP_N, total bits per signed fixed-point lane value.
REQ-002 The block SHALL have parameter FBITS, default FXP_R, fractional bits per lane.
REQ-003 The block SHALL have parameter LANES, default 4, number of parallel radicands per transaction.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1, radicand vector valid.
REQ-007 The block SHALL have port in_ready, output, 1, block can accept a vector.
REQ-008 The block SHALL have port in_rad, input, LANES*WIDTH, radicands; lane i is bits [i*WIDTH +: WIDTH].
REQ-009 The block SHALL have port out_valid, output, 1, results valid.
REQ-010 The block SHALL have port out_ready, input, 1, consumer accepts results.
REQ-011 The block SHALL have port out_root, output, LANES*WIDTH, square roots in the same Q format and lane order.
REQ-012 The block SHALL have port out_rem, output, LANES*WIDTH, unsigned remainders: (rad<<FBITS) - root_unrounded^2.
REQ-013 The block SHALL have port out_err, output, LANES, per-lane negative-input flag.
REQ-014 The block SHALL have port busy, output, 1, high while in CALC.

Function
REQ-015 The block SHALL implement the FSM states IDLE, CALC and DONE.
REQ-016 In IDLE, in_ready SHALL be 1; in CALC and DONE, in_ready SHALL be 0.
REQ-017 in_valid&&in_ready at a rising edge SHALL latch in_rad, clear the iteration counter and enter CALC.
REQ-018 ITER SHALL equal (WIDTH+FBITS)/2; an odd WIDTH+FBITS SHALL be an elaboration error.
REQ-019 CALC SHALL perform one restoring digit-by-digit iteration per cycle on every lane in parallel, using one shared counter.
REQ-020 On the ITER-th edge after the accept edge, the block SHALL enter DONE and assert out_valid; latency is fixed and independent of data.
REQ-021 In DONE, out_root, out_rem and out_err SHALL hold stable until out_valid&&out_ready; out_ready is ignored outside DONE.
REQ-022 out_valid&&out_ready SHALL return the block to IDLE, and in_ready SHALL be 1 in the next cycle; transactions do not overlap.
REQ-023 A lane whose radicand MSB is 1 SHALL yield root 0, rem 0 and out_err[i]=1; the other lanes are unaffected.
REQ-024 A zero radicand SHALL yield root 0, rem 0 and err 0.
REQ-025 The root result SHALL be non-negative and SHALL fit WIDTH bits without saturation.
REQ-026 The remainder SHALL fit WIDTH bits because rem ≤ 2*root.
REQ-027 in_rad changes after the accept edge SHALL NOT affect the running computation.

Reset
REQ-028 reset_n=0 sampled at an edge SHALL force IDLE, clear the counter and clear out_valid, out_root, out_rem, out_err and busy; in_ready SHALL be 1 after release.
REQ-029 Reset asserted in CALC or DONE SHALL abort the computation; no out_valid pulse SHALL follow the release of reset.

Configuration
REQ-030 With FXP_SQRT_ROUND_EN defined, out_root SHALL be root+1 when rem > root (round to nearest), with no latency change, and out_rem SHALL remain the unrounded remainder.
REQ-031 Without FXP_SQRT_ROUND_EN, out_root SHALL be truncated (floor).

Structure
REQ-032 FXP_N, FXP_R and the FSM state enum typedef SHALL live in the shared fxp_pkg.
REQ-033 The per-lane iteration datapath (x, q, ac registers plus the test-subtract step) SHALL be the sub-module fxp_sqrt_lane, instantiated LANES times by generate; the FSM and counter stay in the top level.

Verification
REQ-034 WIDTH=16, FBITS=8, lane0=0x1000 (16.0) -> root 0x0400, rem 0, err 0, out_valid exactly 12 edges after accept.
REQ-035 Lanes {0x0200, 0x0040, 0x0000, 0x6400} -> roots {0x016A, 0x0080, 0x0000, 0x0A00}; lane0 rem 0x001C.
REQ-036 Lane 0x0A00 (10.0) -> root 0x0329 without the macro, 0x032A with FXP_SQRT_ROUND_EN; rem 0x036F in both builds.
REQ-037 Lane 0xFF00 alongside lane 0x0400 -> err 1 on the negative lane with root 0 and rem 0; the other lane gives root 0x0200 and err 0.
REQ-038 out_ready held low for 5 cycles in DONE -> outputs stable and in_ready 0 throughout; after acceptance, a back-to-back next vector is accepted in the following cycle.
REQ-039 reset_n pulsed low at CALC iteration 6 -> IDLE with all outputs zero and no spurious out_valid; the next transaction gives correct results.
